// File: rtl/fpga250_cfg_pkg.sv
// Shared constants, fill-state encoding and lane control struct for the config chain receiver.
package fpga250_cfg_pkg;

   localparam int CFG_LANES_DEF = 4;
   localparam int CFG_DEPTH_DEF = 32;

   typedef enum logic [1:0] {
      FILL_EMPTY   = 2'd0,
      FILL_PARTIAL = 2'd1,
      FILL_FULL    = 2'd2,
      FILL_OVER    = 2'd3
   } fill_state_e;

   typedef struct packed {
      logic shift_en;
      logic commit_en;
   } lane_ctrl_t;

   // Counter value to fill state; depth is the number of bits held per lane.
   function automatic fill_state_e fill_of(input int cnt, input int depth);
      if (cnt == 0)
         return FILL_EMPTY;
      else if (cnt < depth)
         return FILL_PARTIAL;
      else if (cnt == depth)
         return FILL_FULL;
      else
         return FILL_OVER;
   endfunction

endpackage

// File: rtl/config_lane_shifter.sv
// One config lane: DEPTH-bit serial shift register plus the shadow copy it commits into.
module config_lane_shifter
   import fpga250_cfg_pkg::*;
#(
   parameter int DEPTH = CFG_DEPTH_DEF
) (
   input  logic             gclk,
   input  logic             grst_n,
   input  lane_ctrl_t       ctrl,
   input  logic             din,
   output logic             dout,
   output logic [DEPTH-1:0] shadow
);

   logic [DEPTH-1:0] sr;

   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
         sr     <= '0;
         shadow <= '0;
      end else begin
         if (ctrl.shift_en)
            sr <= {sr[DEPTH-2:0], din};
         // Commit copies the pre-edge register; the shift register itself is untouched.
         if (ctrl.commit_en)
            shadow <= sr;
      end
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/config_chain_receiver.sv
// Multi-lane config chain receiver: shifts serial frames, commits them to shadow on set.
// Optional macro CFG_RX_COUNT_CHECK_EN: only commit when exactly DEPTH bits were shifted.
module config_chain_receiver
   import fpga250_cfg_pkg::*;
#(
   parameter int LANES = CFG_LANES_DEF,
   parameter int DEPTH = CFG_DEPTH_DEF
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_ni,
   input  logic                   cen_i,
   input  logic                   set_i,
   input  logic [LANES-1:0]       shift_i,
   output logic                   cen_o,
   output logic                   set_o,
   output logic [LANES-1:0]       shift_o,
   output logic [LANES*DEPTH-1:0] cfg_o,
   output logic                   cfg_valid_o,
   output logic                   commit_o,
   output logic                   cfg_err_o
);

   localparam int CNT_W = $clog2(DEPTH + 2);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH + 1);

   logic [CNT_W-1:0]            shift_cnt;
   logic [CNT_W-1:0]            shift_cnt_nxt;
   fill_state_e                 fill;
   logic                        do_shift;
   logic                        do_set;
   logic                        set_ok;
   lane_ctrl_t                  lane_ctrl;
   logic [LANES-1:0][DEPTH-1:0] lane_shadow;

   assign cen_o = cen_i;
   assign set_o = set_i;

   assign do_shift = cen_i & ~set_i;
   assign do_set   = cen_i & set_i;
   assign fill     = fill_of(32'(shift_cnt), DEPTH);

   always_comb begin
      set_ok             = 1'b1;
`ifdef CFG_RX_COUNT_CHECK_EN
      set_ok             = (fill == FILL_FULL);
`endif
      lane_ctrl.shift_en  = do_shift;
      lane_ctrl.commit_en = do_set & set_ok;
      shift_cnt_nxt       = shift_cnt;
      // Any set restarts the frame count, whether or not it was accepted.
      if (do_set)
         shift_cnt_nxt = '0;
      else if (do_shift && fill != FILL_OVER)
         shift_cnt_nxt = shift_cnt + 1'b1;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         shift_cnt   <= '0;
         commit_o    <= 1'b0;
         cfg_valid_o <= 1'b0;
      end else begin
         shift_cnt   <= (shift_cnt_nxt > CNT_MAX) ? CNT_MAX : shift_cnt_nxt;
         commit_o    <= lane_ctrl.commit_en;
         cfg_valid_o <= cfg_valid_o | lane_ctrl.commit_en;
      end
   end

`ifdef CFG_RX_COUNT_CHECK_EN
   logic cfg_err_q;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni)
         cfg_err_q <= 1'b0;
      else
         cfg_err_q <= do_set & ~set_ok;
   end

   assign cfg_err_o = cfg_err_q;
`else
   assign cfg_err_o = 1'b0;
`endif

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      config_lane_shifter #(
         .DEPTH(DEPTH)
      ) u_lane (
         .gclk   (wb_clk_i),
         .grst_n (wb_rst_ni),
         .ctrl   (lane_ctrl),
         .din    (shift_i[l]),
         .dout   (shift_o[l]),
         .shadow (lane_shadow[l])
      );
   end

   // Packed [lane][bit] flattens to cfg_o[l*DEPTH+k].
   assign cfg_o = lane_shadow;

endmodule

// File: tb/tb_config_chain_receiver.sv
// Directed bench for config_chain_receiver (LANES=4, DEPTH=8), both macro settings.
module tb_config_chain_receiver;

   localparam int LANES = 4;
   localparam int DEPTH = 8;

   logic                   wb_clk_i = 1'b0;
   logic                   wb_rst_ni;
   logic                   cen_i;
   logic                   set_i;
   logic [LANES-1:0]       shift_i;
   logic                   cen_o;
   logic                   set_o;
   logic [LANES-1:0]       shift_o;
   logic [LANES*DEPTH-1:0] cfg_o;
   logic                   cfg_valid_o;
   logic                   commit_o;
   logic                   cfg_err_o;

   int errors = 0;
   int checks = 0;

   config_chain_receiver #(.LANES(LANES), .DEPTH(DEPTH)) dut (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_ni   (wb_rst_ni),
      .cen_i       (cen_i),
      .set_i       (set_i),
      .shift_i     (shift_i),
      .cen_o       (cen_o),
      .set_o       (set_o),
      .shift_o     (shift_o),
      .cfg_o       (cfg_o),
      .cfg_valid_o (cfg_valid_o),
      .commit_o    (commit_o),
      .cfg_err_o   (cfg_err_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample 1ns after the rising edge.
   task automatic cyc(input logic c, input logic s, input logic [LANES-1:0] d);
      cen_i   = c;
      set_i   = s;
      shift_i = d;
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic chk_outs(input string tag, input logic [31:0] cfg, input logic vld,
                           input logic cmt, input logic err);
      chk({tag, "_cfg"}, 64'(cfg_o), 64'(cfg));
      chk({tag, "_valid"}, 64'(cfg_valid_o), 64'(vld));
      chk({tag, "_commit"}, 64'(commit_o), 64'(cmt));
      chk({tag, "_err"}, 64'(cfg_err_o), 64'(err));
   endtask

   initial begin
      logic [7:0]  b;
      logic [7:0]  p;
      logic [8:0]  d9;
      logic [31:0] exp_cfg;
      logic        sent[9];
      logic [LANES-1:0] so_hold;

      wb_rst_ni = 1'b0;
      cen_i     = 1'b0;
      set_i     = 1'b0;
      shift_i   = '0;
      repeat (3) @(posedge wb_clk_i);
      #1;
      chk_outs("reset", 32'h0, 1'b0, 1'b0, 1'b0);
      chk("reset_shift_o", 64'(shift_o), 64'h0);
      chk("reset_cnt", 64'(dut.shift_cnt), 64'h0);
      #3 wb_rst_ni = 1'b1;
      @(posedge wb_clk_i);
      #1;

      // Full frame: lane0 10110010, lane1 inverted, lane2 ones, lane3 zeros
      b = 8'b10110010;
      for (int i = 7; i >= 0; i--) cyc(1'b1, 1'b0, {1'b0, 1'b1, ~b[i], b[i]});
      chk("frame_shift_o", 64'(shift_o), 64'h5);
      chk("frame_cnt", 64'(dut.shift_cnt), 64'd8);
      chk_outs("frame_pre_set", 32'h0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'h0);
      exp_cfg = 32'h00ff4db2;
      chk_outs("commit1", exp_cfg, 1'b1, 1'b1, 1'b0);
      chk("commit1_cnt", 64'(dut.shift_cnt), 64'h0);
      // Back-to-back second set
      cyc(1'b1, 1'b1, 4'h0);
`ifdef CFG_RX_COUNT_CHECK_EN
      chk_outs("set2", exp_cfg, 1'b1, 1'b0, 1'b1);
`else
      chk_outs("set2", exp_cfg, 1'b1, 1'b1, 1'b0);
`endif
      cyc(1'b0, 1'b0, 4'h0);
      chk_outs("idle1", exp_cfg, 1'b1, 1'b0, 1'b0);

      // Short frame: 5 shifts of all-ones
      repeat (5) cyc(1'b1, 1'b0, 4'hF);
      chk("short_cnt", 64'(dut.shift_cnt), 64'd5);
      cyc(1'b1, 1'b1, 4'h0);
`ifdef CFG_RX_COUNT_CHECK_EN
      chk_outs("short_set", exp_cfg, 1'b1, 1'b0, 1'b1);
`else
      exp_cfg = 32'h1fffbf5f;
      chk_outs("short_set", exp_cfg, 1'b1, 1'b1, 1'b0);
`endif
      chk("short_cnt_clr", 64'(dut.shift_cnt), 64'h0);
      cyc(1'b0, 1'b0, 4'h0);
      chk_outs("idle2", exp_cfg, 1'b1, 1'b0, 1'b0);

      // Over frame: 9 shifts on lane0; MSB replays bit k-8
      d9 = 9'b100110101;
      for (int k = 0; k < 9; k++) begin
         sent[k] = d9[8-k];
         cyc(1'b1, 1'b0, {3'b000, d9[8-k]});
         if (k >= 7) chk($sformatf("over_msb_%0d", k + 1), 64'(shift_o[0]), 64'(sent[k-7]));
      end
      chk("over_cnt", 64'(dut.shift_cnt), 64'd9);
      cyc(1'b1, 1'b1, 4'h0);
`ifdef CFG_RX_COUNT_CHECK_EN
      chk_outs("over_set", exp_cfg, 1'b1, 1'b0, 1'b1);
`else
      exp_cfg = 32'h00000035;
      chk_outs("over_set", exp_cfg, 1'b1, 1'b1, 1'b0);
`endif

      // cen_i low: toggling inputs must be ignored
      so_hold = 4'h0;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, i[0], 4'(i * 5 + 3));
         chk($sformatf("cen0_%0d_outs", i),
             {cfg_o, so_hold, cfg_valid_o, commit_o, cfg_err_o, set_o, cen_o},
             {exp_cfg, shift_o, 1'b1, 1'b0, 1'b0, i[0], 1'b0});
      end
      chk("cen0_cnt", 64'(dut.shift_cnt), 64'h0);

      // Reset after 4 of 8 shifts, then a clean frame
      p = 8'b01101001;
      for (int i = 7; i >= 4; i--) cyc(1'b1, 1'b0, {1'b1, p[i], ~p[i], p[i]});
      chk("mid_cnt", 64'(dut.shift_cnt), 64'd4);
      wb_rst_ni = 1'b0;
      #2;
      chk_outs("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
      chk("async_rst_shift_o", 64'(shift_o), 64'h0);
      chk("async_rst_cnt", 64'(dut.shift_cnt), 64'h0);
      #3 wb_rst_ni = 1'b1;
      for (int i = 7; i >= 0; i--) cyc(1'b1, 1'b0, {1'b1, p[i], ~p[i], p[i]});
      chk("post_rst_cnt", 64'(dut.shift_cnt), 64'd8);
      chk_outs("post_rst_pre_set", 32'h0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'h0);
      exp_cfg = 32'hff699669;
      chk_outs("post_rst_commit", exp_cfg, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 4'h0);
      chk_outs("post_rst_idle", exp_cfg, 1'b1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/config_chain_receiver.md
CONFIG_CHAIN_RECEIVER -- requirements
Module: config_chain_receiver

Interface
REQ-001 SHALL have parameter LANES, default 4: number of parallel config shift lanes.
REQ-002 SHALL have parameter DEPTH, default 32: bits held per lane, minimum 2.
REQ-003 SHALL have port wb_clk_i, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port wb_rst_ni, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port cen_i, input, 1: config enable from the upstream configurator.
REQ-006 SHALL have port set_i, input, 1: commit strobe, qualified by cen_i.
REQ-007 SHALL have port shift_i, input, LANES: serial data in, one bit per lane.
REQ-008 SHALL have port cen_o, input-to-output passthrough, 1: equals cen_i combinationally.
REQ-009 SHALL have port set_o, output, 1: equals set_i combinationally.
REQ-010 SHALL have port shift_o, output, LANES: daisy-chain data out, bit l = MSB of lane l shift register.
REQ-011 SHALL have port cfg_o, output, LANES*DEPTH: committed configuration, cfg_o[l*DEPTH+k] = lane l shadow bit k.
REQ-012 SHALL have port cfg_valid_o, output, 1: sticky, high once any commit has succeeded.
REQ-013 SHALL have port commit_o, output, 1: one-cycle pulse on each successful commit.
REQ-014 SHALL have port cfg_err_o, output, 1: one-cycle pulse on each rejected commit.

Function
REQ-015 SHALL shift when cen_i=1 and set_i=0: lane l register <= {reg[DEPTH-2:0], shift_i[l]}; first bit sent reaches MSB after DEPTH shifts.
REQ-016 SHALL commit when cen_i=1 and set_i=1: shadow <= shift registers (pre-edge values); no shift that cycle.
REQ-017 SHALL ignore shift_i and set_i when cen_i=0; all registers hold.
REQ-018 SHALL keep a shift counter, width clog2(DEPTH+2), incremented per shift, saturating at DEPTH+1, cleared on every set (accepted or rejected).
REQ-019 SHALL derive fill state from the counter: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH), OVER (DEPTH+1); transitions only on shift (up) or set (to EMPTY).
REQ-020 SHALL update cfg_o one cycle after the commit edge's sampling, i.e. visible on the edge where set is sampled; commit_o high in the following cycle only.
REQ-021 SHALL leave shift registers unchanged by a commit, so a repeated set re-commits identical data.
REQ-022 SHALL assert cfg_valid_o from the first successful commit until reset.

Reset
REQ-023 SHALL on wb_rst_ni=0 immediately clear shift registers, shadow (cfg_o=0), counter (EMPTY), cfg_valid_o=0, commit_o=0, cfg_err_o=0.
REQ-024 SHALL discard a partially shifted frame on reset mid-shift; no commit results.
REQ-025 SHALL resume normal operation on the first clock edge after wb_rst_ni deasserts.

Configuration
REQ-026 SHALL support macro CFG_RX_COUNT_CHECK_EN.
REQ-027 SHALL, with CFG_RX_COUNT_CHECK_EN defined, commit only in state FULL; set in EMPTY/PARTIAL/OVER leaves cfg_o unchanged, pulses cfg_err_o, no commit_o.
REQ-028 SHALL, without the macro, commit on every set regardless of count; cfg_err_o tied 0.

Structure
REQ-029 SHALL place fill-state enum (EMPTY/PARTIAL/FULL/OVER) and default LANES/DEPTH constants in shared package fpga250_cfg_pkg.
REQ-030 SHALL instantiate one sub-module per lane, config_lane_shifter (DEPTH-bit shift register plus shadow); counter and control remain in the top.

Verification
REQ-031 SHALL cover: DEPTH=8, LANES=4, shift 8 words with lane0 pattern 1,0,1,1,0,0,1,0 then set -> cfg_o[7:0]=8'b10110010, commit_o one pulse, cfg_valid_o=1.
REQ-032 SHALL cover: macro on, 5 shifts then set -> cfg_err_o one pulse, cfg_o unchanged, counter 0; macro off -> commit with 3 stale bits.
REQ-033 SHALL cover: 9 shifts then set with macro on -> state OVER, rejected; shift_o[0] over those cycles reproduces first bit delayed 8 shifts.
REQ-034 SHALL cover: cen_i=0 with toggling shift_i/set_i for 20 cycles -> no register change, no pulses.
REQ-035 SHALL cover: wb_rst_ni low after 4 of 8 shifts -> cfg_o=0, cfg_valid_o=0 immediately; next full frame commits correctly.
REQ-036 SHALL cover: two back-to-back set cycles after a full frame -> first commits, second rejected (macro on) or recommits identical data (macro off).
